// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one active-low column at a time, classifies each
// full scan frame as none/single/multi, and debounces presses and releases.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_detected,
  output logic       key_pulse
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [FW-1:0] FRAMES     = FW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_CHECK, HELD, RELEASE_CHECK} state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;
      4'h2: key_code = 4'd3;   4'h3: key_code = 4'd10;
      4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;
      4'h6: key_code = 4'd6;   4'h7: key_code = 4'd11;
      4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;
      4'ha: key_code = 4'd9;   4'hb: key_code = 4'd12;
      4'hc: key_code = 4'd0;   4'hd: key_code = 4'd15;
      4'he: key_code = 4'd14;  4'hf: key_code = 4'd13;
      default: key_code = 4'd0;
    endcase
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q, col_d;
  // acc_cnt saturates at 2: anything beyond one pressed position is a multi-key frame
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          frm_vld_q, frm_vld_d;
  logic [1:0]    frm_cnt_q, frm_cnt_d;
  logic [3:0]    frm_code_q, frm_code_d;

  logic [3:0]    pressed;
  logic [2:0]    hits, sum;
  logic [1:0]    hit_row, merged_cnt;
  logic [3:0]    merged_code;
  logic          dwell_last;

  always_comb begin
    pressed    = ~row_s2_q;
    hits       = {2'b00, pressed[0]} + {2'b00, pressed[1]} +
                 {2'b00, pressed[2]} + {2'b00, pressed[3]};
    hit_row    = 2'd0;
    for (int r = 3; r >= 0; r--)
      if (pressed[r]) hit_row = 2'(r);
    sum         = {1'b0, acc_cnt_q} + hits;
    merged_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    merged_code = (acc_cnt_q == 2'd0 && hits == 3'd1) ? key_code(hit_row, col_idx_q) : acc_code_q;

    dwell_last = (dwell_q == DWELL_LAST);
    dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
    col_idx_d  = col_idx_q;
    col_d      = col_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    frm_vld_d  = 1'b0;
    frm_cnt_d  = frm_cnt_q;
    frm_code_d = frm_code_q;
    if (dwell_last) begin
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      if (col_idx_q == 2'd3) begin
        frm_vld_d  = 1'b1;
        frm_cnt_d  = merged_cnt;
        frm_code_d = merged_code;
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_cnt_d  = merged_cnt;
        acc_code_d = merged_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      dwell_q    <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      frm_vld_q  <= 1'b0;
      frm_cnt_q  <= 2'd0;
      frm_code_q <= 4'd0;
    end else begin
      row_s1_q   <= row;
      row_s2_q   <= row_s1_q;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      frm_vld_q  <= frm_vld_d;
      frm_cnt_q  <= frm_cnt_d;
      frm_code_q <= frm_code_d;
    end
  end

  state_t        state_q;
  logic [3:0]    cand_q, key_q;
  logic [FW-1:0] cnt_q, cnt_inc;
  logic          key_detected_q, key_pulse_q;
  logic          f_none, f_single;

  assign cnt_inc  = cnt_q + 1'b1;
  assign f_none   = (frm_cnt_q == 2'd0);
  assign f_single = (frm_cnt_q == 2'd1);

  // Debounce runs once per frame, the cycle after the column-3 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cand_q         <= 4'd0;
      cnt_q          <= '0;
      key_q          <= 4'd0;
      key_detected_q <= 1'b0;
      key_pulse_q    <= 1'b0;
    end else begin
      key_pulse_q <= 1'b0;
      if (frm_vld_q) begin
        case (state_q)
          IDLE: if (f_single) begin
            cand_q  <= frm_code_q;
            cnt_q   <= FW'(1);
            state_q <= PRESS_CHECK;
          end
          PRESS_CHECK: begin
            if (f_single && frm_code_q == cand_q) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == FRAMES) begin
                state_q        <= HELD;
                key_q          <= cand_q;
                key_detected_q <= 1'b1;
                key_pulse_q    <= 1'b1;
              end
            end else if (f_single) begin
              cand_q <= frm_code_q;
              cnt_q  <= FW'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: if (f_none) begin
            cnt_q   <= FW'(1);
            state_q <= RELEASE_CHECK;
          end
          RELEASE_CHECK: begin
            if (f_none) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == FRAMES) begin
                state_q        <= IDLE;
                key_detected_q <= 1'b0;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= HELD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col          = col_q;
  assign key          = key_q;
  assign key_detected = key_detected_q;
  assign key_pulse    = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model pulls rows low under the active
// column; scenarios check scan order, debounce, rejection and reset behaviour.
module tb_keypad_scanner;
  localparam int SC = 8, DF = 3, LAT_MAX = 131;

  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] row, col, key;
  logic key_detected, key_pulse;
  logic [15:0] pressed = '0;  // bit r*4+c
  int tests = 0, fails = 0;
  int pulse_cnt = 0, consec = 0;
  logic pulse_prev = 1'b0;
  int code_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int model_key = 0;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key(key),
    .key_detected(key_detected), .key_pulse(key_pulse));

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_pulse) pulse_cnt <= pulse_cnt + 1;
    if (key_pulse && pulse_prev) consec <= consec + 1;
    pulse_prev <= key_pulse;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output bit found, output int lat);
    found = 0; lat = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      step(1);
      if (key_pulse) begin found = 1; lat = i; end
    end
  endtask

  task automatic wait_kd_low(input int budget, output bit found, output int lat);
    found = 0; lat = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      step(1);
      if (!key_detected) begin found = 1; lat = i; end
    end
  endtask

  task automatic test_reset;
    int col_err, out_err;
    logic [3:0] e;
    rst = 1'b1; pressed = '0;
    step(3);
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", col); end
    tests++; if (key !== 4'd0) begin fails++; $display("FAIL reset_key: got %0d want 0", key); end
    tests++; if (key_detected !== 1'b0) begin fails++; $display("FAIL reset_kd: got %b want 0", key_detected); end
    tests++; if (key_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", key_pulse); end
    rst = 1'b0;
    col_err = 0; out_err = 0;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      e = ~(4'b0001 << ((k / SC) % 4));
      if (col !== e) col_err++;
      if (key_detected !== 1'b0 || key_pulse !== 1'b0) out_err++;
    end
    tests++; if (col_err != 0) begin fails++; $display("FAIL col_sequence: got %0d bad cycles want 0", col_err); end
    tests++; if (out_err != 0) begin fails++; $display("FAIL idle_outputs: got %0d active cycles want 0", out_err); end
  endtask

  task automatic test_press_key(input int r, input int c);
    bit found; int lat, base;
    int exp_code;
    exp_code = code_tbl[r*4+c];
    base = pulse_cnt;
    pressed[r*4+c] = 1'b1;
    wait_pulse(LAT_MAX + 4, found, lat);
    tests++; if (!found || lat > LAT_MAX) begin fails++; $display("FAIL press_latency_%0d: got %0d cycles want <=%0d", exp_code, lat, LAT_MAX); end
    tests++; if (key !== 4'(exp_code)) begin fails++; $display("FAIL press_key_%0d: got %0d want %0d", exp_code, key, exp_code); end
    tests++; if (key_detected !== 1'b1) begin fails++; $display("FAIL press_kd_%0d: got %b want 1", exp_code, key_detected); end
    step(300 - lat);
    tests++; if (pulse_cnt - base != 1) begin fails++; $display("FAIL press_pulses_%0d: got %0d want 1", exp_code, pulse_cnt - base); end
    pressed = '0;
    step(150);
    tests++; if (key_detected !== 1'b0 || key !== 4'(exp_code)) begin fails++; $display("FAIL after_release_%0d: got kd=%b key=%0d want kd=0 key=%0d", exp_code, key_detected, key, exp_code); end
  endtask

  task automatic test_short_press;
    int base, kd_hi;
    base = pulse_cnt; kd_hi = 0;
    pressed[0*4+1] = 1'b1;
    for (int i = 0; i < 40; i++) begin step(1); if (key_detected) kd_hi++; end
    pressed = '0;
    for (int i = 0; i < 150; i++) begin step(1); if (key_detected) kd_hi++; end
    tests++; if (pulse_cnt != base) begin fails++; $display("FAIL short_pulses: got %0d want 0", pulse_cnt - base); end
    tests++; if (kd_hi != 0) begin fails++; $display("FAIL short_kd: got %0d high cycles want 0", kd_hi); end
  endtask

  task automatic test_release_glitch;
    bit found; int lat, base, kd_lo;
    base = pulse_cnt; kd_lo = 0;
    pressed[1*4+1] = 1'b1;
    wait_pulse(LAT_MAX + 4, found, lat);
    tests++; if (!found) begin fails++; $display("FAIL glitch_accept: got no pulse want pulse"); end
    step(100);
    pressed = '0;
    for (int i = 0; i < 30; i++) begin step(1); if (!key_detected) kd_lo++; end
    pressed[1*4+1] = 1'b1;
    for (int i = 0; i < 100; i++) begin step(1); if (!key_detected) kd_lo++; end
    tests++; if (kd_lo != 0) begin fails++; $display("FAIL glitch_kd: got %0d low cycles want 0", kd_lo); end
    tests++; if (pulse_cnt - base != 1) begin fails++; $display("FAIL glitch_pulses: got %0d want 1", pulse_cnt - base); end
    pressed = '0;
    wait_kd_low(LAT_MAX + 8, found, lat);
    tests++; if (!found || lat > LAT_MAX || lat < 64) begin fails++; $display("FAIL release_latency: got %0d cycles want 64..%0d", lat, LAT_MAX); end
    tests++; if (key !== 4'd5) begin fails++; $display("FAIL release_key: got %0d want 5", key); end
    step(20);
  endtask

  task automatic test_multi_key;
    bit found; int lat, base, kd_hi;
    base = pulse_cnt; kd_hi = 0;
    pressed[0*4+0] = 1'b1;
    pressed[3*4+1] = 1'b1;
    for (int i = 0; i < 200; i++) begin step(1); if (key_detected) kd_hi++; end
    tests++; if (pulse_cnt != base || kd_hi != 0) begin fails++; $display("FAIL multi_reject: got pulses=%0d kd_cycles=%0d want 0 0", pulse_cnt - base, kd_hi); end
    pressed[3*4+1] = 1'b0;
    wait_pulse(LAT_MAX + 4, found, lat);
    tests++; if (!found || key !== 4'd1) begin fails++; $display("FAIL multi_then_single: got found=%0d key=%0d want 1 1", found, key); end
    pressed = '0;
    step(150);
  endtask

  task automatic test_reset_mid;
    bit found; int lat, base;
    pressed[2*4+2] = 1'b1;
    wait_pulse(LAT_MAX + 4, found, lat);
    tests++; if (!found || key !== 4'd9) begin fails++; $display("FAIL held9: got found=%0d key=%0d want 1 9", found, key); end
    step(50);
    #2 rst = 1'b1;
    #1;
    tests++; if (col !== 4'b1110 || key !== 4'd0 || key_detected !== 1'b0 || key_pulse !== 1'b0) begin
      fails++; $display("FAIL async_reset: got col=%b key=%0d kd=%b pulse=%b want 1110 0 0 0", col, key, key_detected, key_pulse);
    end
    step(3);
    rst = 1'b0;
    base = pulse_cnt;
    wait_pulse(LAT_MAX + 4, found, lat);
    tests++; if (!found || lat < 64) begin fails++; $display("FAIL reaccept_latency: got found=%0d lat=%0d want lat>=64", found, lat); end
    tests++; if (key !== 4'd9) begin fails++; $display("FAIL reaccept_key: got %0d want 9", key); end
    step(100);
    tests++; if (pulse_cnt - base != 1) begin fails++; $display("FAIL reaccept_pulses: got %0d want 1", pulse_cnt - base); end
    pressed = '0;
    step(150);
    model_key = 9;
  endtask

  // Model: a press held well past the debounce window yields one pulse and
  // sets key to the map code; a brief press yields nothing and key is kept.
  task automatic test_random_seq;
    int idx, dur, base, exp_pulses;
    bit long_press;
    for (int n = 0; n < 10; n++) begin
      idx = $urandom_range(0, 15);
      long_press = 1'($urandom_range(0, 1));
      dur = long_press ? $urandom_range(140, 220) : $urandom_range(5, 45);
      base = pulse_cnt;
      pressed = '0;
      pressed[idx] = 1'b1;
      step(dur);
      pressed = '0;
      step($urandom_range(150, 190));
      exp_pulses = long_press ? 1 : 0;
      if (long_press) model_key = code_tbl[idx];
      tests++; if (pulse_cnt - base != exp_pulses) begin fails++; $display("FAIL rand_pulses_%0d: got %0d want %0d (pos %0d dur %0d)", n, pulse_cnt - base, exp_pulses, idx, dur); end
      tests++; if (key !== 4'(model_key) || key_detected !== 1'b0) begin fails++; $display("FAIL rand_key_%0d: got key=%0d kd=%b want key=%0d kd=0", n, key, key_detected, model_key); end
    end
  endtask

  initial begin
    test_reset;
    test_press_key(1, 1);
    test_press_key(3, 1);
    test_short_press;
    test_release_glitch;
    test_multi_key;
    test_reset_mid;
    test_random_seq;
    tests++; if (consec != 0) begin fails++; $display("FAIL pulse_back_to_back: got %0d want 0", consec); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
